// File: rtl/task1_cpu_cpu_debug_ocimem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : task1_cpu_cpu_debug_ocimem_pkg
// Brief    : Shared types and JTAG data-field positions for the OCI debug RAM.
// Revision : 1.0
// ============================================================================
package task1_cpu_cpu_debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } ocimem_state_t;

    localparam int RD_REQ_BIT = 35;
    localparam int ADDR_MSB   = 33;
    localparam int ADDR_LSB   = 26;
    localparam int WDATA_MSB  = 34;
    localparam int WDATA_LSB  = 3;

endpackage
`default_nettype wire

// File: rtl/task1_cpu_cpu_debug_ocimem_ram.sv
`default_nettype none
// ============================================================================
// Module   : task1_cpu_cpu_debug_ocimem_ram
// Brief    : DEPTHx32 single-port synchronous RAM, 4 byte enables, 1-cycle read.
// Revision : 1.0
// ============================================================================
module task1_cpu_cpu_debug_ocimem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    localparam int          c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [31:0]     r_mem [0:DEPTH-1];
    logic [31:0]     r_q;
    logic            w_in_range;
    logic [c_iw-1:0] w_idx;

    // Out-of-range words never alias onto real storage and read back as zero.
    assign w_in_range = ({1'b0, addr} < c_depth);
    assign w_idx      = addr[c_iw-1:0];

    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        r_q <= w_in_range ? r_mem[w_idx] : 32'h0;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/task1_cpu_cpu_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module   : task1_cpu_cpu_debug_ocimem
// Brief    : On-chip debug RAM shared by JTAG debug strobes and an Avalon-MM slave.
// Revision : 1.0
// ============================================================================
module task1_cpu_cpu_debug_ocimem
    import task1_cpu_cpu_debug_ocimem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic [AW-1:0] MonAReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    ocimem_state_t r_state;
    logic [AW-1:0] r_mon_a;
    logic [31:0]   r_mon_d;
    logic [31:0]   r_jwr_data;
    logic          r_ready;
    logic          r_error;
    logic          r_jrd_pend;
    logic          r_jwr_pend;

    logic [AW-1:0] w_jdo_addr;
    logic          w_jdo_addr_oor;
    logic [AW-1:0] w_mon_a_inc;
    logic          w_mon_a_inc_oor;
    logic          w_take_a;
    logic          w_take_b;
    logic          w_take_n;
    logic          w_jtag_busy;
    logic          w_idle;
    logic          w_cpu_wr_go;
    logic          w_cpu_rd_go;
    logic [AW-1:0] w_ram_addr;
    logic          w_ram_we;
    logic [3:0]    w_ram_be;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_q;
    logic          w_unused_jdo;

    assign w_jdo_addr      = AW'(jdo[ADDR_MSB:ADDR_LSB]);
    assign w_jdo_addr_oor  = ({1'b0, w_jdo_addr} >= c_depth);
    assign w_mon_a_inc     = r_mon_a + 1'b1;
    assign w_mon_a_inc_oor = ({1'b0, w_mon_a_inc} >= c_depth);
    assign w_unused_jdo    = ^{jdo[37:36], jdo[2:0]};

    assign w_take_a = take_action_ocimem_a;
    assign w_take_b = take_action_ocimem_b & ~take_action_ocimem_a;
    assign w_take_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // A strobe arriving this cycle already blocks the CPU so JTAG wins ties.
    assign w_jtag_busy = r_jrd_pend | r_jwr_pend | take_action_ocimem_a |
                         take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_idle      = (r_state == IDLE);
    assign w_cpu_wr_go = w_idle & ~w_jtag_busy & avs_write;
    assign w_cpu_rd_go = w_idle & ~w_jtag_busy & ~avs_write & avs_read;

    assign avs_waitrequest = (avs_read | avs_write) &
                             ~(w_cpu_wr_go | ((r_state == C_RD) & avs_read));
    assign avs_readdata    = (r_state == C_RD) ? w_ram_q : 32'h0;

    always_comb begin
        w_ram_addr  = r_mon_a;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'hF;
        w_ram_wdata = r_jwr_data;
        if (w_idle && r_jwr_pend) begin
            w_ram_we = ~reset;
        end else if (w_cpu_wr_go) begin
            w_ram_addr  = avs_address;
            w_ram_we    = ~reset;
            w_ram_be    = avs_byteenable;
            w_ram_wdata = avs_writedata;
        end else if (w_cpu_rd_go) begin
            w_ram_addr = avs_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mon_a    <= '0;
            r_mon_d    <= 32'h0;
            r_jwr_data <= 32'h0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_jrd_pend <= 1'b0;
            r_jwr_pend <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_jwr_pend) begin
                        r_jwr_pend <= 1'b0;
                        r_mon_a    <= w_mon_a_inc;
                        if (w_mon_a_inc_oor) r_error <= 1'b1;
                    end else if (r_jrd_pend) begin
                        r_state <= J_RD;
                    end else if (w_cpu_rd_go) begin
                        r_state <= C_RD;
                    end
                end
                J_RD: begin
                    r_mon_d    <= w_ram_q;
                    r_ready    <= 1'b1;
                    r_mon_a    <= w_mon_a_inc;
                    r_jrd_pend <= 1'b0;
                    r_state    <= IDLE;
                    if (w_mon_a_inc_oor) r_error <= 1'b1;
                end
                C_RD: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Strobe handling comes last so an address load overrides an increment.
            if (w_take_a) begin
                if (r_jrd_pend) begin
                    r_error <= 1'b1;
                end else begin
                    r_mon_a <= w_jdo_addr;
                    r_ready <= 1'b0;
                    r_error <= w_jdo_addr_oor;
                    if (jdo[RD_REQ_BIT] && !w_jdo_addr_oor) r_jrd_pend <= 1'b1;
                end
            end else if (w_take_b) begin
                if (!r_error) begin
                    if (r_jwr_pend) begin
                        r_error <= 1'b1;
                    end else begin
                        r_jwr_pend <= 1'b1;
                        r_jwr_data <= jdo[WDATA_MSB:WDATA_LSB];
                    end
                end
            end else if (w_take_n) begin
                if (!r_error) begin
                    if (r_jrd_pend) begin
                        r_error <= 1'b1;
                    end else begin
                        r_jrd_pend <= 1'b1;
                        r_ready    <= 1'b0;
                    end
                end
            end
        end
    end

    task1_cpu_cpu_debug_ocimem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .be    (w_ram_be),
        .wdata (w_ram_wdata),
        .q     (w_ram_q)
    );

    assign MonDReg       = r_mon_d;
    assign MonAReg       = r_mon_a;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

endmodule
`default_nettype wire
